// File: rtl/w_handler.sv
// Write-data stage for the traffic generator.
// Snoops accepted AW handshakes, queues their burst lengths, emits matching W bursts
// with a deterministic data pattern, then sinks and counts B responses.

module w_handler #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    aw_valid_i,
    input  logic                    aw_ready_i,
    input  logic [7:0]              aw_len_i,
    output logic                    aw_block_o,
    output logic                    w_valid_o,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    input  logic                    w_ready_i,
    input  logic                    b_valid_i,
    input  logic [1:0]              b_resp_i,
    output logic                    b_ready_o,
    output logic                    busy_o,
    output logic [CNT_WIDTH-1:0]    done_cnt_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    output logic                    overflow_o,
    output logic                    unexp_b_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OUT_W = PTR_W + 8;
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_DATA
    } state_e;

    // Pending-AW FIFO
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_req;
    logic             push;
    logic             pop;

    // W burst state
    state_e           state_q;
    state_e           state_d;
    logic [7:0]       len_q;
    logic [7:0]       beat_q;
    logic [31:0]      seq_q;
    logic             w_hs;
    logic             last_hs;

    // B side and bookkeeping
    logic [OUT_W-1:0]     out_q;
    logic [CNT_WIDTH-1:0] done_q;
    logic [CNT_WIDTH-1:0] err_q;
    logic                 ovf_q;
    logic                 unexp_q;
    logic                 b_ready_q;
    logic                 b_hs;
    logic                 b_unexp;
    logic                 b_take;

    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    assign push_req   = aw_valid_i && aw_ready_i;
    // A full FIFO still takes the push when the same cycle frees a slot.
    assign push       = push_req && (!fifo_full || pop);

    assign w_last_o = (state_q == ST_DATA) && (beat_q == len_q);
    assign w_valid_o = (state_q == ST_DATA);
    assign w_hs     = w_valid_o && w_ready_i;
    assign last_hs  = w_hs && w_last_o;

    assign b_ready_o = b_ready_q;
    assign b_hs      = b_valid_i && b_ready_q;
    // A B that arrives with nothing outstanding is only legal if a burst closes in the same cycle.
    assign b_unexp   = b_hs && (out_q == '0) && !last_hs;
    assign b_take    = b_hs && !b_unexp;

    assign aw_block_o = fifo_full;
    assign busy_o     = !fifo_empty || (state_q == ST_DATA) || (out_q != '0);
    assign done_cnt_o = done_q;
    assign err_cnt_o  = err_q;
    assign overflow_o = ovf_q;
    assign unexp_b_o  = unexp_q;

    // Next-state logic: pop a length whenever a new burst can start, back-to-back if possible.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_hs) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data pattern: beat index in the low word, burst sequence number above it.
    always_comb begin
        w_data_o = '0;
        w_strb_o = '0;
        if (state_q == ST_DATA) begin
            w_data_o[31:0]  = {24'd0, beat_q};
            w_data_o[63:32] = seq_q;
            w_strb_o        = '1;
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately left out of reset; the pointers and count define which entries are valid.
        if (push) begin
            mem_q[wr_ptr_q] <= aw_len_i;
        end
    end

    // FIFO pointers, occupancy and overflow detection.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // W FSM state register and burst datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                len_q  <= mem_q[rd_ptr_q];
                beat_q <= '0;
            end else if (w_hs && !w_last_o) begin
                beat_q <= beat_q + 8'd1;
            end
            if (last_hs) begin
                seq_q <= seq_q + 32'd1;
            end
        end
    end

    // Outstanding bursts, B acceptance, response counters and unexpected-B flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_ready_q <= 1'b0;
            out_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            unexp_q   <= 1'b0;
        end else begin
            b_ready_q <= 1'b1;
            if (last_hs && !b_take) begin
                if (out_q != '1) begin
                    out_q <= out_q + OUT_W'(1);
                end
            end else if (b_take && !last_hs) begin
                out_q <= out_q - OUT_W'(1);
            end
            if (b_take && (done_q != '1)) begin
                done_q <= done_q + CNT_WIDTH'(1);
            end
            if (b_hs && (b_resp_i != 2'b00) && (err_q != '1)) begin
                err_q <= err_q + CNT_WIDTH'(1);
            end
            if (b_unexp) begin
                unexp_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_w_handler.sv
// Self-checking bench for w_handler: a directed vector table for the basic burst,
// back-to-back and B-response behaviour, plus hand-written multi-cycle sequences.

module tb_w_handler;

    localparam int DW = 64;
    localparam int CW = 16;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            aw_valid_i = 1'b0;
    logic            aw_ready_i = 1'b0;
    logic [7:0]      aw_len_i = '0;
    logic            aw_block_o;
    logic            w_valid_o;
    logic [DW-1:0]   w_data_o;
    logic [DW/8-1:0] w_strb_o;
    logic            w_last_o;
    logic            w_ready_i = 1'b0;
    logic            b_valid_i = 1'b0;
    logic [1:0]      b_resp_i = '0;
    logic            b_ready_o;
    logic            busy_o;
    logic [CW-1:0]   done_cnt_o;
    logic [CW-1:0]   err_cnt_o;
    logic            overflow_o;
    logic            unexp_b_o;

    int n_cmp = 0;
    int n_mis = 0;

    w_handler #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_i (aw_ready_i),
        .aw_len_i   (aw_len_i),
        .aw_block_o (aw_block_o),
        .w_valid_o  (w_valid_o),
        .w_data_o   (w_data_o),
        .w_strb_o   (w_strb_o),
        .w_last_o   (w_last_o),
        .w_ready_i  (w_ready_i),
        .b_valid_i  (b_valid_i),
        .b_resp_i   (b_resp_i),
        .b_ready_o  (b_ready_o),
        .busy_o     (busy_o),
        .done_cnt_o (done_cnt_o),
        .err_cnt_o  (err_cnt_o),
        .overflow_o (overflow_o),
        .unexp_b_o  (unexp_b_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int rst; int awv; int awr; int len; int wr; int bv; int resp;
        int e_wv; int e_wl; int e_beat; int e_seq; int e_blk; int e_busy;
        int e_brdy; int e_done; int e_err; int e_ovf; int e_unexp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        aw_valid_i = 1'b0;
        aw_ready_i = 1'b0;
        aw_len_i = '0;
        w_ready_i = 1'b0;
        b_valid_i = 1'b0;
        b_resp_i = '0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic set_aw(input logic v, input logic [7:0] len);
        aw_valid_i = v;
        aw_ready_i = v;
        aw_len_i = len;
    endtask

    initial begin
        int hs;
        int lasts;
        int beats;
        int idx;
        logic prev_stall;
        logic prev_last;
        logic [63:0] prev_data;
        int exp_len[5];
        vec_t v;

        // rst awv awr len wr bv resp | wv wl beat seq blk busy brdy done err ovf unexp
        // Single burst len=3 then OKAY response.
        tbl.push_back('{0,1,1,3,1,0,0, 0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 0,0,0,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 1,0,0,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 1,0,1,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 1,0,2,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 1,1,3,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,1,0, 0,0,0,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 0,0,0,0,0,0,1,1,0,0,0});
        // Reset, then three back-to-back AWs of len 0,1,0.
        tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,0,0,0});
        tbl.push_back('{0,1,1,0,1,0,0, 0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,1,1,0,0, 0,0,0,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,1,1,0,1,0,0, 1,1,0,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 1,0,0,1,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 1,1,1,1,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,0, 1,1,0,2,0,1,1,0,0,0,0});
        // B responses: SLVERR, OKAY, OKAY, then one with nothing outstanding.
        tbl.push_back('{0,0,1,0,1,1,2, 0,0,0,0,0,1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,1,0, 0,0,0,0,0,1,1,1,1,0,0});
        tbl.push_back('{0,0,1,0,1,1,0, 0,0,0,0,0,1,1,2,1,0,0});
        tbl.push_back('{0,0,1,0,1,1,0, 0,0,0,0,0,0,1,3,1,0,0});
        // AW valid without ready must not be queued.
        tbl.push_back('{0,1,0,5,1,0,0, 0,0,0,0,0,0,1,3,1,0,1});
        tbl.push_back('{0,0,0,0,1,0,0, 0,0,0,0,0,0,1,3,1,0,1});

        // ---------------- reset state ----------------
        do_reset();
        check("rst w_valid", 64'(w_valid_o), 64'd0);
        check("rst w_last", 64'(w_last_o), 64'd0);
        check("rst w_data", 64'(w_data_o), 64'd0);
        check("rst w_strb", 64'(w_strb_o), 64'd0);
        check("rst b_ready", 64'(b_ready_o), 64'd0);
        check("rst aw_block", 64'(aw_block_o), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst done_cnt", 64'(done_cnt_o), 64'd0);
        check("rst err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst overflow", 64'(overflow_o), 64'd0);
        check("rst unexp_b", 64'(unexp_b_o), 64'd0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rst_i      = v.rst[0];
            aw_valid_i = v.awv[0];
            aw_ready_i = v.awr[0];
            aw_len_i   = v.len[7:0];
            w_ready_i  = v.wr[0];
            b_valid_i  = v.bv[0];
            b_resp_i   = v.resp[1:0];
            check($sformatf("row%0d w_valid", i), 64'(w_valid_o), 64'(v.e_wv));
            check($sformatf("row%0d w_last", i), 64'(w_last_o), 64'(v.e_wl));
            if (v.e_wv != 0) begin
                check($sformatf("row%0d beat", i), 64'(w_data_o[31:0]), 64'(v.e_beat));
                check($sformatf("row%0d seq", i), 64'(w_data_o[63:32]), 64'(v.e_seq));
            end
            check($sformatf("row%0d aw_block", i), 64'(aw_block_o), 64'(v.e_blk));
            check($sformatf("row%0d busy", i), 64'(busy_o), 64'(v.e_busy));
            check($sformatf("row%0d b_ready", i), 64'(b_ready_o), 64'(v.e_brdy));
            check($sformatf("row%0d done_cnt", i), 64'(done_cnt_o), 64'(v.e_done));
            check($sformatf("row%0d err_cnt", i), 64'(err_cnt_o), 64'(v.e_err));
            check($sformatf("row%0d overflow", i), 64'(overflow_o), 64'(v.e_ovf));
            check($sformatf("row%0d unexp_b", i), 64'(unexp_b_o), 64'(v.e_unexp));
            step();
        end

        // ---------------- stalled burst len=7 with random w_ready ----------------
        do_reset();
        set_aw(1'b1, 8'd7);
        step();
        set_aw(1'b0, 8'd0);
        hs = 0;
        lasts = 0;
        prev_stall = 1'b0;
        prev_last = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 200 && hs < 8; c++) begin
            w_ready_i = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check("stall w_valid held", 64'(w_valid_o), 64'd1);
                check("stall w_data held", 64'(w_data_o), prev_data);
                check("stall w_last held", 64'(w_last_o), 64'(prev_last));
            end
            if (w_valid_o) begin
                check("stall beat", 64'(w_data_o[31:0]), 64'(hs));
                check("stall seq", 64'(w_data_o[63:32]), 64'd0);
                check("stall strb", 64'(w_strb_o), 64'hff);
                check("stall w_last", 64'(w_last_o), 64'(hs == 7));
                if (w_ready_i) begin
                    hs++;
                    if (w_last_o) lasts++;
                end
            end
            prev_stall = w_valid_o && !w_ready_i;
            prev_data = 64'(w_data_o);
            prev_last = w_last_o;
            step();
        end
        check("stall handshakes", 64'(hs), 64'd8);
        check("stall wlast count", 64'(lasts), 64'd1);
        check("stall idle after", 64'(w_valid_o), 64'd0);

        // W-last and B in the same cycle keep outstanding at 1.
        set_aw(1'b1, 8'd0);
        w_ready_i = 1'b1;
        step();
        set_aw(1'b0, 8'd0);
        step();
        check("same-cycle w_last", 64'(w_last_o), 64'd1);
        b_valid_i = 1'b1;
        b_resp_i = 2'b00;
        step();
        check("same-cycle done", 64'(done_cnt_o), 64'd1);
        check("same-cycle busy", 64'(busy_o), 64'd1);
        step();
        check("drain done", 64'(done_cnt_o), 64'd2);
        check("drain busy", 64'(busy_o), 64'd0);
        check("drain unexp", 64'(unexp_b_o), 64'd0);
        step();
        check("extra B unexp", 64'(unexp_b_o), 64'd1);
        check("extra B done", 64'(done_cnt_o), 64'd2);
        b_valid_i = 1'b0;

        // ---------------- FIFO full, overflow and push-with-pop ----------------
        do_reset();
        w_ready_i = 1'b0;
        set_aw(1'b1, 8'd1);
        step();
        set_aw(1'b1, 8'd2);
        step();
        set_aw(1'b1, 8'd3);
        step();
        set_aw(1'b1, 8'd4);
        step();
        check("fill block before last", 64'(aw_block_o), 64'd0);
        set_aw(1'b1, 8'd5);
        step();
        check("full aw_block", 64'(aw_block_o), 64'd1);
        check("full no overflow", 64'(overflow_o), 64'd0);
        set_aw(1'b0, 8'd0);
        w_ready_i = 1'b1;
        step();
        check("full w_last", 64'(w_last_o), 64'd1);
        set_aw(1'b1, 8'd9);
        step();
        check("push+pop overflow", 64'(overflow_o), 64'd0);
        check("push+pop block", 64'(aw_block_o), 64'd1);
        check("push+pop next seq", 64'(w_data_o[63:32]), 64'd1);
        check("push+pop next beat", 64'(w_data_o[31:0]), 64'd0);
        set_aw(1'b1, 8'd10);
        w_ready_i = 1'b0;
        step();
        check("drop overflow", 64'(overflow_o), 64'd1);
        check("drop block", 64'(aw_block_o), 64'd1);
        set_aw(1'b0, 8'd0);
        w_ready_i = 1'b1;
        exp_len = '{3, 4, 5, 6, 10};
        beats = 0;
        idx = 0;
        for (int c = 0; c < 100; c++) begin
            if (!w_valid_o) break;
            beats++;
            if (w_last_o) begin
                if (idx < 5) begin
                    check($sformatf("drain burst%0d beats", idx), 64'(beats), 64'(exp_len[idx]));
                    check($sformatf("drain burst%0d seq", idx), 64'(w_data_o[63:32]), 64'(idx + 1));
                end
                idx++;
                beats = 0;
            end
            step();
        end
        check("drain burst count", 64'(idx), 64'd5);
        check("drain fifo empty", 64'(aw_block_o), 64'd0);

        // ---------------- reset mid-burst ----------------
        set_aw(1'b1, 8'd5);
        b_valid_i = 1'b1;
        b_resp_i = 2'b01;
        step();
        set_aw(1'b0, 8'd0);
        b_valid_i = 1'b0;
        check("pre-rst done", 64'(done_cnt_o), 64'd1);
        check("pre-rst err", 64'(err_cnt_o), 64'd1);
        step();
        check("pre-rst seq", 64'(w_data_o[63:32]), 64'd6);
        step();
        step();
        check("pre-rst beat", 64'(w_data_o[31:0]), 64'd2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mid-rst w_valid", 64'(w_valid_o), 64'd0);
        check("mid-rst w_last", 64'(w_last_o), 64'd0);
        check("mid-rst done", 64'(done_cnt_o), 64'd0);
        check("mid-rst err", 64'(err_cnt_o), 64'd0);
        check("mid-rst overflow", 64'(overflow_o), 64'd0);
        check("mid-rst busy", 64'(busy_o), 64'd0);
        step();
        check("post-rst w_valid", 64'(w_valid_o), 64'd0);
        check("post-rst b_ready", 64'(b_ready_o), 64'd1);
        set_aw(1'b1, 8'd1);
        step();
        set_aw(1'b0, 8'd0);
        step();
        check("restart beat", 64'(w_data_o[31:0]), 64'd0);
        check("restart seq", 64'(w_data_o[63:32]), 64'd0);
        check("restart w_last", 64'(w_last_o), 64'd0);
        step();
        check("restart last beat", 64'(w_last_o), 64'd1);
        step();
        check("restart done", 64'(w_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
